// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared constants, instruction field positions and helpers for the dual-issue scheduler
package sched_pkg;

  localparam int NUM_REGS = 32;
  localparam int INSTR_W  = 27;
  localparam int CNT_W    = 16;

  localparam int RS1_MSB    = 26;
  localparam int RS1_LSB    = 22;
  localparam int RS2_MSB    = 21;
  localparam int RS2_LSB    = 17;
  localparam int RD_MSB     = 16;
  localparam int RD_LSB     = 12;
  localparam int ALUSEL_MSB = 11;
  localparam int ALUSEL_LSB = 8;
  localparam int WEN        = 7;
  localparam int WBSEL      = 6;
  localparam int ALUSRC     = 5;
  localparam int BRANCH     = 4;
  localparam int MEMWRITEEN = 3;
  localparam int USES_RD    = 2;
  localparam int USES_RS1   = 1;
  localparam int USES_RS2   = 0;

  // Loads (WBSel) and stores share the single memory port.
  function automatic logic is_mem(input logic [INSTR_W-1:0] instr);
    return instr[WBSEL] | instr[MEMWRITEEN];
  endfunction

endpackage

// File: rtl/sb_hazard_check.sv
// rtl/sb_hazard_check.sv - combinational RAW/WAW lookup of one instruction against the scoreboard
module sb_hazard_check
  import sched_pkg::*;
(
  input  logic [INSTR_W-1:0]  instr,
  input  logic [NUM_REGS-1:0] sb,
  output logic                raw_busy,
  output logic                waw_busy
);

  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic       unused_fields;

  assign rs1 = instr[RS1_MSB:RS1_LSB];
  assign rs2 = instr[RS2_MSB:RS2_LSB];
  assign rd  = instr[RD_MSB:RD_LSB];
  assign unused_fields = ^instr[ALUSEL_MSB:MEMWRITEEN];

  // x0 is hardwired zero, so it is never treated as pending.
  assign raw_busy = (instr[USES_RS1] && (rs1 != 5'd0) && sb[rs1]) ||
                    (instr[USES_RS2] && (rs2 != 5'd0) && sb[rs2]);
  assign waw_busy = instr[USES_RD] && (rd != 5'd0) && sb[rd];

endmodule

// File: rtl/dual_issue_scoreboard.sv
// rtl/dual_issue_scoreboard.sv - in-order dual-issue controller with register scoreboard
// Optional SB_WB_BYPASS_EN: hazard checks see this cycle's writeback clears.
module dual_issue_scoreboard
  import sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid_1,
  input  logic [INSTR_W-1:0] in_instr_1,
  input  logic               in_valid_2,
  input  logic [INSTR_W-1:0] in_instr_2,
  output logic [1:0]         deq_count,
  input  logic               ex_stall,
  input  logic               flush,
  output logic               iss_valid_1,
  output logic [INSTR_W-1:0] iss_instr_1,
  output logic               iss_valid_2,
  output logic [INSTR_W-1:0] iss_instr_2,
  input  logic               wb_valid_1,
  input  logic [4:0]         wb_rd_1,
  input  logic               wb_valid_2,
  input  logic [4:0]         wb_rd_2,
  output logic [CNT_W-1:0]   stall_cnt
);

  logic [NUM_REGS-1:0] sb;
  logic [NUM_REGS-1:0] sb_chk;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] flush_mask;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] sb_next;

  logic raw1, waw1, raw2, waw2;
  logic pair_hazard, ready1, ready2, hold, issue1, issue2;

  logic [4:0] rd1, rd2, rs1_2, rs2_2, iss_rd1, iss_rd2;
  assign rd1     = in_instr_1[RD_MSB:RD_LSB];
  assign rd2     = in_instr_2[RD_MSB:RD_LSB];
  assign rs1_2   = in_instr_2[RS1_MSB:RS1_LSB];
  assign rs2_2   = in_instr_2[RS2_MSB:RS2_LSB];
  assign iss_rd1 = iss_instr_1[RD_MSB:RD_LSB];
  assign iss_rd2 = iss_instr_2[RD_MSB:RD_LSB];

  always_comb begin
    clr_mask = '0;
    if (wb_valid_1 && (wb_rd_1 != 5'd0)) clr_mask[wb_rd_1] = 1'b1;
    if (wb_valid_2 && (wb_rd_2 != 5'd0)) clr_mask[wb_rd_2] = 1'b1;
  end

`ifdef SB_WB_BYPASS_EN
  assign sb_chk = sb & ~clr_mask;
`else
  assign sb_chk = sb;
`endif

  sb_hazard_check u_chk1 (.instr(in_instr_1), .sb(sb_chk), .raw_busy(raw1), .waw_busy(waw1));
  sb_hazard_check u_chk2 (.instr(in_instr_2), .sb(sb_chk), .raw_busy(raw2), .waw_busy(waw2));

  // Pair-internal conflicts the scoreboard cannot see: slot 1 has not issued yet.
  assign pair_hazard =
      (in_instr_1[USES_RD] && (rd1 != 5'd0) &&
       ((in_instr_2[USES_RS1] && (rs1_2 == rd1)) ||
        (in_instr_2[USES_RS2] && (rs2_2 == rd1)) ||
        (in_instr_2[USES_RD]  && (rd2   == rd1)))) ||
      in_instr_1[BRANCH] ||
      (is_mem(in_instr_1) && is_mem(in_instr_2));

  assign ready1 = in_valid_1 && !raw1 && !waw1;
  assign ready2 = ready1 && in_valid_2 && !raw2 && !waw2 && !pair_hazard;

  assign hold      = ex_stall || flush;
  assign issue1    = ready1 && !hold;
  assign issue2    = ready2 && !hold;
  assign deq_count = {1'b0, issue1} + {1'b0, issue2};

  always_comb begin
    set_mask   = '0;
    flush_mask = '0;
    if (issue1 && in_instr_1[USES_RD] && (rd1 != 5'd0)) set_mask[rd1] = 1'b1;
    if (issue2 && in_instr_2[USES_RD] && (rd2 != 5'd0)) set_mask[rd2] = 1'b1;
    // WAW blocking means an in-flight rd has no older producer, so dropping it is safe.
    if (flush && iss_valid_1 && iss_instr_1[USES_RD] && (iss_rd1 != 5'd0)) flush_mask[iss_rd1] = 1'b1;
    if (flush && iss_valid_2 && iss_instr_2[USES_RD] && (iss_rd2 != 5'd0)) flush_mask[iss_rd2] = 1'b1;
  end

  assign sb_next = (sb & ~clr_mask & ~flush_mask) | set_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb <= '0;
    end else begin
      sb <= sb_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid_1 <= 1'b0;
      iss_instr_1 <= '0;
      iss_valid_2 <= 1'b0;
      iss_instr_2 <= '0;
    end else if (flush) begin
      iss_valid_1 <= 1'b0;
      iss_instr_1 <= '0;
      iss_valid_2 <= 1'b0;
      iss_instr_2 <= '0;
    end else if (!ex_stall) begin
      iss_valid_1 <= issue1;
      iss_instr_1 <= issue1 ? in_instr_1 : '0;
      iss_valid_2 <= issue2;
      iss_instr_2 <= issue2 ? in_instr_2 : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (in_valid_1 && (deq_count == 2'd0) && !ex_stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// tb/tb_dual_issue_scoreboard.sv - scoreboard-checked directed bench for dual_issue_scoreboard
module tb_dual_issue_scoreboard;
  import sched_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid_1, in_valid_2;
  logic [INSTR_W-1:0] in_instr_1, in_instr_2;
  logic [1:0]         deq_count;
  logic               ex_stall, flush;
  logic               iss_valid_1, iss_valid_2;
  logic [INSTR_W-1:0] iss_instr_1, iss_instr_2;
  logic               wb_valid_1, wb_valid_2;
  logic [4:0]         wb_rd_1, wb_rd_2;
  logic [CNT_W-1:0]   stall_cnt;

  dual_issue_scoreboard dut (
    .clk(clk), .rst(rst),
    .in_valid_1(in_valid_1), .in_instr_1(in_instr_1),
    .in_valid_2(in_valid_2), .in_instr_2(in_instr_2),
    .deq_count(deq_count), .ex_stall(ex_stall), .flush(flush),
    .iss_valid_1(iss_valid_1), .iss_instr_1(iss_instr_1),
    .iss_valid_2(iss_valid_2), .iss_instr_2(iss_instr_2),
    .wb_valid_1(wb_valid_1), .wb_rd_1(wb_rd_1),
    .wb_valid_2(wb_valid_2), .wb_rd_2(wb_rd_2),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic               v1;
    logic [INSTR_W-1:0] i1;
    logic               v2;
    logic [INSTR_W-1:0] i2;
  } item_t;

  item_t q[$];
  item_t last_item = '0;
  logic  last_hold = 1'b0;
  int    tests = 0;
  int    fails = 0;
  int    exp_stall = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk(input int rd, input int rs1, input int rs2,
                                            input logic ur, input logic u1, input logic u2,
                                            input logic wbs, input logic mw, input logic br);
    logic [INSTR_W-1:0] x;
    x = '0;
    x[RS1_MSB:RS1_LSB] = rs1[4:0];
    x[RS2_MSB:RS2_LSB] = rs2[4:0];
    x[RD_MSB:RD_LSB]   = rd[4:0];
    x[WEN]        = ur;
    x[WBSEL]      = wbs;
    x[BRANCH]     = br;
    x[MEMWRITEEN] = mw;
    x[USES_RD]    = ur;
    x[USES_RS1]   = u1;
    x[USES_RS2]   = u2;
    return x;
  endfunction

  function automatic logic [INSTR_W-1:0] add(input int rd, input int rs1, input int rs2);
    return mk(rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  always @(posedge clk) last_hold <= ex_stall && !flush;

  // Monitor: every fresh issue pops one expectation; held cycles must repeat the last one.
  always @(negedge clk) begin
    if (!rst) begin
      if (last_hold) begin
        chk("hold_regs", {iss_valid_1, iss_instr_1, iss_valid_2, iss_instr_2}, last_item);
      end else if (iss_valid_1 || iss_valid_2) begin
        if (q.size() == 0) begin
          chk("unexpected_issue", {iss_valid_1, iss_instr_1, iss_valid_2, iss_instr_2}, 64'd0);
          last_item = '0;
        end else begin
          last_item = q.pop_front();
          chk("issue", {iss_valid_1, iss_instr_1, iss_valid_2, iss_instr_2}, last_item);
        end
      end else begin
        last_item = '0;
      end
    end
  end

  task automatic cyc(input string nm, input logic v1, input logic [INSTR_W-1:0] i1,
                     input logic v2, input logic [INSTR_W-1:0] i2,
                     input logic st, input logic fl, input logic [4:0] w1, input logic [4:0] w2,
                     input int exp);
    item_t it;
    in_valid_1 = v1;  in_instr_1 = i1;
    in_valid_2 = v2;  in_instr_2 = i2;
    ex_stall = st;    flush = fl;
    wb_valid_1 = (w1 != 5'd0); wb_rd_1 = w1;
    wb_valid_2 = (w2 != 5'd0); wb_rd_2 = w2;
    #1;
    chk({nm, "_deq"}, 64'(deq_count), 64'(exp));
    if (exp > 0) begin
      it.v1 = 1'b1;
      it.i1 = i1;
      it.v2 = (exp == 2);
      it.i2 = (exp == 2) ? i2 : '0;
      q.push_back(it);
    end
    if (v1 && exp == 0 && !st && exp_stall < 65535) exp_stall++;
    @(posedge clk);
    #1;
    chk({nm, "_stall_cnt"}, 64'(stall_cnt), 64'(exp_stall));
  endtask

  localparam logic [INSTR_W-1:0] Z = '0;

  initial begin
    logic [INSTR_W-1:0] ld7, use7, ld20, st_i, brn;
    ld7  = mk(7, 2, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    use7 = add(8, 7, 3);
    ld20 = mk(20, 2, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    st_i = mk(0, 2, 3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    brn  = mk(0, 2, 3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    rst = 1'b1;
    in_valid_1 = 1'b0; in_instr_1 = '0; in_valid_2 = 1'b0; in_instr_2 = '0;
    ex_stall = 1'b0; flush = 1'b0;
    wb_valid_1 = 1'b0; wb_rd_1 = '0; wb_valid_2 = 1'b0; wb_rd_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {iss_valid_1, iss_valid_2}, 64'd0);
    chk("rst_instr", {iss_instr_1, iss_instr_2}, 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_deq", 64'(deq_count), 64'd0);
    rst = 1'b0;

    cyc("pair",     1, add(1, 2, 3),   1, add(4, 5, 6),  0, 0, 0, 0, 2);
    cyc("rawpair",  1, add(10, 11, 12), 1, add(13, 10, 0), 0, 0, 0, 0, 1);
    cyc("rawwait",  1, add(13, 10, 0), 0, Z, 0, 0, 0, 0, 0);
`ifdef SB_WB_BYPASS_EN
    cyc("rawwb",    1, add(13, 10, 0), 0, Z, 0, 0, 10, 0, 1);
`else
    cyc("rawwb",    1, add(13, 10, 0), 0, Z, 0, 0, 10, 0, 0);
    cyc("rawafter", 1, add(13, 10, 0), 0, Z, 0, 0, 0, 0, 1);
`endif
    cyc("wbclr",    0, Z, 0, Z, 0, 0, 1, 4, 0);
    cyc("wbsame",   0, Z, 0, Z, 0, 0, 13, 13, 0);

    cyc("ldpair",   1, ld7,  1, use7, 0, 0, 0, 0, 1);
    cyc("ldwait",   1, use7, 0, Z,    0, 0, 0, 0, 0);
`ifdef SB_WB_BYPASS_EN
    cyc("ldwb",     1, use7, 0, Z,    0, 0, 7, 0, 1);
`else
    cyc("ldwb",     1, use7, 0, Z,    0, 0, 7, 0, 0);
    cyc("ldafter",  1, use7, 0, Z,    0, 0, 0, 0, 1);
`endif

    cyc("mempair",  1, ld20, 1, st_i, 0, 0, 0, 0, 1);
    cyc("memst",    1, st_i, 0, Z,    0, 0, 0, 0, 1);
    cyc("brpair",   1, brn,  1, add(21, 2, 3), 0, 0, 0, 0, 1);
    cyc("brnext",   1, add(21, 2, 3), 0, Z, 0, 0, 0, 0, 1);
    cyc("waw",      1, add(20, 2, 3), 0, Z, 0, 0, 0, 0, 0);
    cyc("wawpair",  1, add(22, 2, 3), 1, add(22, 5, 6), 0, 0, 0, 0, 1);
    cyc("x0pair",   1, add(0, 2, 3),  1, add(0, 0, 5),  0, 0, 0, 0, 2);
    cyc("x0read",   1, add(24, 0, 0), 0, Z, 0, 0, 0, 0, 1);

    cyc("stpair",   1, add(4, 2, 3),  1, add(23, 2, 3), 0, 0, 0, 0, 2);
    for (int k = 0; k < 3; k++)
      cyc("stall",  1, add(25, 4, 0), 0, Z, 1, 0, 4, 0, 0);
    cyc("afterstall", 1, add(25, 4, 0), 0, Z, 0, 0, 0, 0, 1);

    cyc("iss9",     1, add(9, 2, 3),  0, Z, 0, 0, 0, 0, 1);
    cyc("flush",    1, add(26, 9, 0), 0, Z, 1, 1, 0, 0, 0);
    chk("flush_valid", {iss_valid_1, iss_valid_2}, 64'd0);
    cyc("read9",    1, add(26, 9, 0), 0, Z, 0, 0, 0, 0, 1);

    cyc("prerst",   1, add(27, 2, 3), 1, add(28, 2, 3), 0, 0, 0, 0, 2);
    @(negedge clk);
    #1;
    rst = 1'b1;
    in_valid_1 = 1'b0; in_valid_2 = 1'b0;
    #1;
    chk("async_rst_valid", {iss_valid_1, iss_valid_2}, 64'd0);
    chk("async_rst_stall_cnt", 64'(stall_cnt), 64'd0);
    exp_stall = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("postrst",  1, add(29, 27, 28), 0, Z, 0, 0, 0, 0, 1);
    cyc("idle1",    0, Z, 0, Z, 0, 0, 0, 0, 0);
    cyc("idle2",    0, Z, 0, Z, 0, 0, 0, 0, 0);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
